// File: rtl/avs_arb_pkg.sv
// rtl/avs_arb_pkg.sv - shared types and helpers for the video frame arbiter
package avs_arb_pkg;

    // One-hot FSM encoding for the frame arbiter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_FRAME = 2'b10
    } state_t;

    // Width of the line counter: must hold the value H after the final EOL
    function automatic int line_cnt_w(input int h);
        return $clog2(h) + 1;
    endfunction

endpackage

// File: rtl/avs_rr_pick.sv
// rtl/avs_rr_pick.sv - combinational round-robin picker, first request at or after pointer
module avs_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    int w_dist;
    int w_best;

    // Winner is the requester with the smallest circular distance from the pointer
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_best  = N;
        w_dist  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - int'(i_ptr)) % N;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avs_frame_arbiter.sv
// rtl/avs_frame_arbiter.sv - frame-boundary arbiter sharing one video stream among N sources
module avs_frame_arbiter
    import avs_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int D = 8,
    parameter int H = 480
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [N-1:0]   s_tvalid,
    output logic [N-1:0]   s_tready,
    input  logic [N*D-1:0] s_tdata,
    input  logic [N-1:0]   s_tuser,
    input  logic [N-1:0]   s_tlast,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic [D-1:0]   m_tdata,
    output logic           m_tuser,
    output logic           m_tlast,
    output logic [N-1:0]   grant,
    output logic           frame_done,
    output logic           frame_err
);

    localparam int LW = line_cnt_w(H);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_grant;
    logic [PW-1:0]   r_rr_ptr;
    logic [LW-1:0]   r_line_cnt;
    logic            r_beat_seen;
    logic            r_frame_done;
    logic            r_frame_err;

    logic [N-1:0]    w_pick_grant;
    logic            w_pick_valid;
    logic [PW-1:0]   w_next_ptr;
    logic            w_own_valid;
    logic            w_own_user;
    logic            w_own_last;
    logic [D-1:0]    w_own_data;
    logic            w_in_frame;
    logic            w_hs;
    logic            w_early;
    logic            w_eof;
    logic [LW-1:0]   w_cnt_base;

    // Only sources holding a start of frame compete for ownership
    avs_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_req   (s_tvalid & s_tuser),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    // Pointer moves to the source just after the winner
    always_comb begin
        w_next_ptr = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick_grant[i]) begin
                w_next_ptr = PW'((i + 1) % N);
            end
        end
    end

    // Select the owner's beat; all zero while no source is granted
    always_comb begin
        w_own_valid = 1'b0;
        w_own_user  = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_own_valid = w_own_valid | s_tvalid[i];
                w_own_user  = w_own_user  | s_tuser[i];
                w_own_last  = w_own_last  | s_tlast[i];
                w_own_data  = w_own_data  | s_tdata[i*D +: D];
            end
        end
    end

    assign w_in_frame = (r_state == ST_FRAME);
    assign m_tvalid   = w_in_frame & w_own_valid & ~areset;
    assign m_tdata    = w_own_data;
    assign m_tuser    = w_own_user;
    assign m_tlast    = w_own_last;
    assign w_hs       = m_tvalid & m_tready;

    // An SOF after any forwarded beat restarts the frame count from zero
    assign w_early    = w_hs & w_own_user & ((r_line_cnt != '0) | r_beat_seen);
    assign w_cnt_base = w_early ? '0 : r_line_cnt;
    assign w_eof      = w_hs & w_own_last & (w_cnt_base == LW'(H - 1));

    // Idle flushes mid-frame beats and holds SOF beats; in a frame only the owner sees ready
    always_comb begin
        s_tready = '0;
        if (!areset) begin
            if (w_in_frame) begin
                s_tready = r_grant & {N{m_tready}};
            end else begin
                s_tready = s_tvalid & ~s_tuser;
            end
        end
    end

    // Next-state logic: grant on any held SOF, release after the last line's EOL
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_state_next = ST_FRAME;
            ST_FRAME: if (w_eof)        w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, round-robin pointer and line tracking
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_line_cnt  <= '0;
            r_beat_seen <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_pick_valid) begin
                r_grant     <= w_pick_grant;
                r_rr_ptr    <= w_next_ptr;
                r_line_cnt  <= '0;
                r_beat_seen <= 1'b0;
            end
        end else if (w_eof) begin
            r_grant    <= '0;
            r_line_cnt <= '0;
        end else if (w_hs) begin
            r_beat_seen <= 1'b1;
            r_line_cnt  <= w_own_last ? (w_cnt_base + LW'(1)) : w_cnt_base;
        end
    end

    // Single-cycle status pulses, registered one cycle after the causing handshake
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_eof;
            r_frame_err  <= w_early;
        end
    end

    assign grant      = r_grant;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: doc/avs_frame_arbiter.md
# avs_frame_arbiter

Shares one AXI4-Stream video output between N video sources and switches ownership only on frame boundaries, so downstream blocks always see complete frames: SOF first, then exactly H lines. It sits ahead of the frame-enforcement and marker-generation stages in the video pipeline. Sources that present mid-frame data while unowned are flushed until they reach a start of frame. Grants rotate round-robin among sources presenting SOF.

## Interface
Parameters:
- N, 2, number of source ports (2..8)
- D, 8, tdata width per beat
- H, 480, lines per frame (≥1)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_tvalid  in  N  per-source beat valid
- s_tready  out  N  per-source ready
- s_tdata  in  N*D  source i occupies bits [i*D +: D]
- s_tuser  in  N  per-source SOF marker, first beat of frame
- s_tlast  in  N  per-source EOL marker, last beat of line
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tdata  out  D  output data
- m_tuser  out  1  output SOF
- m_tlast  out  1  output EOL
- grant  out  N  one-hot owner, all-zero when idle
- frame_done  out  1  one-cycle pulse, frame completed
- frame_err  out  1  one-cycle pulse, early SOF from owner

## Operation
- State machine: IDLE, FRAME.
- IDLE:
  - grant = 0 and m_tvalid = 0.
  - For every source with s_tvalid=1 and s_tuser=0, s_tready=1, so the beat is discarded (flush).
  - For every source with s_tvalid=1 and s_tuser=1, s_tready=0, so the beat is held.
  - If any source holds SOF, pick the winner round-robin starting from rr_ptr. Register grant to the winner and move to FRAME. Set rr_ptr = (winner+1) mod N.
- FRAME, with owner g:
  - m_tvalid/tdata/tuser/tlast = s_*[g], combinational.
  - s_tready[g] = m_tready.
  - All other s_tready = 0; non-owners are never flushed during FRAME.
- line_cnt, $clog2(H)+1 bits:
  - Cleared on entry to FRAME.
  - Increments on an output handshake with m_tlast=1.
- End of frame: a handshake with m_tlast=1 while line_cnt==H-1 does the following:
  - frame_done pulses next cycle.
  - State returns to IDLE.
  - grant clears next cycle.
- Early SOF: a handshake with m_tuser=1 while line_cnt≠0, or while line_cnt==0 after a beat has already been passed in this frame, does the following:
  - frame_err pulses next cycle.
  - line_cnt resets to 0.
  - The beat is forwarded as the start of a new frame and the owner is kept.
- SOF and EOL on the same beat with H=1 counts as a complete one-line frame: frame_done pulses and there is no error.
- Owner stalls (s_tvalid low) do not time out; ownership is held indefinitely.

## Timing
- Reset values: state=IDLE, grant=0, rr_ptr=0, line_cnt=0, frame_done=0, frame_err=0. m_tvalid=0 and s_tready=0 while areset=1.
- Data path latency is 0 cycles: combinational pass-through with no buffering.
- Arbitration costs 1 cycle: the SOF is seen in IDLE at cycle t, grant is valid at t+1, and the SOF beat can transfer at t+1.
- There is at least one IDLE cycle between consecutive frames, so back-to-back frames from the same source lose one cycle.
- frame_done and frame_err are registered and each lasts exactly one cycle.
- Reset asserted mid-frame: IDLE takes effect the next cycle, the partial frame is abandoned, and there is no frame_done.
- An input may change during a stall (m_tready=0). Downstream protocol is the source's responsibility; the arbiter does not re-register data.

## Structure
- Package avs_arb_pkg holds:
  - the state enum (IDLE, FRAME, one-hot, 2 bits);
  - the function for the width of line_cnt.
- Sub-module avs_rr_pick holds the combinational round-robin picker:
  - inputs: request vector and pointer;
  - outputs: one-hot winner and valid.
- The picker is reused by future stream schedulers.
- Top level contains the FSM, line counter, grant register, pulse registers and the ready/valid muxing.

## Test plan
- N=2, H=4, source 0 sends a 4-line frame. Expect: grant=01 the cycle after SOF is presented, 4 EOL handshakes, frame_done one cycle after the 4th EOL, then grant=00.
- Both sources present SOF in the same cycle after reset. Expect: source 0 wins, then source 1 owns the next frame. Source 1 s_tready=0 throughout frame 0.
- Source 1 presents 5 non-SOF beats while IDLE. Expect: all 5 accepted with s_tready=1 and discarded, and m_tvalid stays 0 throughout.
- Owner sends SOF at line 2 of a 4-line frame. Expect: frame_err pulses once, line_cnt=0, and a further 4 lines produce frame_done.
- Reset asserted mid-frame on line 1. Expect: next cycle grant=00, m_tvalid=0, and no frame_done. The next SOF is granted to source 0 because rr_ptr was reset.
- H=1, single beat with tuser=tlast=1, m_tready toggling. Expect: frame_done after the handshake only, and no frame_err.
